// File: rtl/branch_tag_allocator_pkg.sv
// Shared branch-tag types: tag-mask width, allocator FSM states and perf counter width.
// `B_MASK_WIDTH overrides the number of branch tags (default 4).
`ifndef B_MASK_WIDTH
`define B_MASK_WIDTH 4
`endif

package sys_defs;

  localparam int unsigned B_MASK_WIDTH   = `B_MASK_WIDTH;
  localparam int unsigned PERF_CNT_WIDTH = 32;

  typedef logic [B_MASK_WIDTH-1:0] B_MASK;

  typedef enum logic {
    BTAG_IDLE,
    BTAG_RECOVER
  } BTAG_STATE_E;

  function automatic logic is_onehot(input B_MASK m);
    return (m != '0) && ((m & (m - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/branch_tag_allocator_free_picker.sv
// Hands out the lowest free tags to requesting lanes in lane order; grants form a prefix.
// Pure combinational.
module btag_free_picker #(
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned B_MASK_WIDTH   = 4
) (
  input  logic [B_MASK_WIDTH-1:0]                     free_mask,
  input  logic [DISPATCH_WIDTH-1:0]                   req,
  output logic [DISPATCH_WIDTH-1:0]                   grant,
  output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0] pick
);

  logic [B_MASK_WIDTH-1:0] remaining;
  logic                    blocked;

  always_comb begin
    remaining = free_mask;
    blocked   = 1'b0;
    grant     = '0;
    pick      = '0;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      if (req[i] && !blocked) begin
        if (remaining != '0) begin
          // Isolate lowest set bit.
          pick[i]   = remaining & (~remaining + 1'b1);
          remaining = remaining & ~pick[i];
          grant[i]  = 1'b1;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch-tag allocator: grants one-hot b_mask tags to dispatch, frees them on resolve and
// squashes younger dependents on mispredict. Define BTAG_PERF_EN to add perf counters.
module branch_tag_allocator
  import sys_defs::*;
#(
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned RECOVER_CYCLES = 1
) (
  input  logic                                        clock,
  input  logic                                        reset_n,
  input  logic [DISPATCH_WIDTH-1:0]                   alloc_req,
  output logic [DISPATCH_WIDTH-1:0]                   alloc_grant,
  output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0] alloc_tag,
  output logic [DISPATCH_WIDTH-1:0][B_MASK_WIDTH-1:0] alloc_dep_mask,
  output logic [B_MASK_WIDTH-1:0]                     b_mask_live,
  input  logic                                        resolve_valid,
  input  logic [B_MASK_WIDTH-1:0]                     resolve_bmm,
  input  logic                                        resolve_mispred,
  output logic [$clog2(B_MASK_WIDTH):0]               free_count,
  output logic                                        stall
`ifdef BTAG_PERF_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0]                   perf_allocs,
  output logic [PERF_CNT_WIDTH-1:0]                   perf_mispreds,
  output logic [PERF_CNT_WIDTH-1:0]                   perf_full_stalls
`endif
);

  localparam int unsigned BMW   = B_MASK_WIDTH;
  localparam int unsigned FC_W  = $clog2(BMW) + 1;
  localparam int unsigned CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  B_MASK                   live_q, live_d;
  logic [BMW-1:0][BMW-1:0] dep_q, dep_d;
  BTAG_STATE_E             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FC_W-1:0]         free_count_q, free_count_d;

  logic                    legal_resolve, good_resolve, mis_resolve, grant_en;
  B_MASK                   squash, clr_col, dep_acc;
  logic [DISPATCH_WIDTH-1:0]          req_eff, grant;
  logic [DISPATCH_WIDTH-1:0][BMW-1:0] pick;

  // Resolves of non-live or non-one-hot tags are dropped entirely.
  assign legal_resolve = resolve_valid && is_onehot(resolve_bmm) && ((resolve_bmm & live_q) != '0);
  assign good_resolve  = legal_resolve && !resolve_mispred;
  assign mis_resolve   = legal_resolve && resolve_mispred;
  assign clr_col       = good_resolve ? resolve_bmm : '0;

  assign grant_en = reset_n && (state_q == BTAG_IDLE) && !mis_resolve;
  assign req_eff  = grant_en ? alloc_req : '0;

  btag_free_picker #(
    .DISPATCH_WIDTH (DISPATCH_WIDTH),
    .B_MASK_WIDTH   (BMW)
  ) u_free_picker (
    .free_mask (~live_q),
    .req       (req_eff),
    .grant     (grant),
    .pick      (pick)
  );

  always_comb begin
    squash = resolve_bmm;
    for (int t = 0; t < int'(BMW); t++) begin
      if ((dep_q[t] & resolve_bmm) != '0) squash[t] = 1'b1;
    end
  end

  always_comb begin
    dep_acc        = live_q;
    alloc_grant    = grant;
    alloc_tag      = pick;
    alloc_dep_mask = '0;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      if (grant[i]) alloc_dep_mask[i] = dep_acc;
      dep_acc = dep_acc | pick[i];
    end
  end

  assign stall = reset_n && ((state_q == BTAG_RECOVER) || ((alloc_req & ~grant) != '0));

  always_comb begin
    live_d = live_q;
    dep_d  = dep_q;
    if (good_resolve) begin
      live_d = live_d & ~resolve_bmm;
      for (int t = 0; t < int'(BMW); t++) dep_d[t] = dep_d[t] & ~clr_col;
    end
    if (mis_resolve) begin
      live_d = live_d & ~squash;
      for (int t = 0; t < int'(BMW); t++) begin
        if (squash[t]) dep_d[t] = '0;
      end
    end
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      if (grant[i]) begin
        live_d = live_d | pick[i];
        for (int t = 0; t < int'(BMW); t++) begin
          if (pick[i][t]) dep_d[t] = alloc_dep_mask[i] & ~clr_col;
        end
      end
    end
    free_count_d = '0;
    for (int t = 0; t < int'(BMW); t++) begin
      if (!live_d[t]) free_count_d = free_count_d + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      BTAG_IDLE: begin
        if (mis_resolve) begin
          state_d = BTAG_RECOVER;
          cnt_d   = CNT_W'(RECOVER_CYCLES - 1);
        end
      end
      BTAG_RECOVER: begin
        if (mis_resolve) begin
          cnt_d = CNT_W'(RECOVER_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = BTAG_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = BTAG_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_q       <= '0;
      dep_q        <= '0;
      state_q      <= BTAG_IDLE;
      cnt_q        <= '0;
      free_count_q <= FC_W'(BMW);
    end else begin
      live_q       <= live_d;
      dep_q        <= dep_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      free_count_q <= free_count_d;
    end
  end

  assign b_mask_live = live_q;
  assign free_count  = free_count_q;

`ifdef BTAG_PERF_EN
  logic [PERF_CNT_WIDTH-1:0] perf_allocs_q, perf_mispreds_q, perf_full_stalls_q;
  logic [PERF_CNT_WIDTH:0]   allocs_sum;
  logic [PERF_CNT_WIDTH-1:0] grant_cnt;

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      if (grant[i]) grant_cnt = grant_cnt + 1'b1;
    end
    allocs_sum = {1'b0, perf_allocs_q} + {1'b0, grant_cnt};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_allocs_q      <= '0;
      perf_mispreds_q    <= '0;
      perf_full_stalls_q <= '0;
    end else begin
      perf_allocs_q <= allocs_sum[PERF_CNT_WIDTH] ? '1 : allocs_sum[PERF_CNT_WIDTH-1:0];
      if (mis_resolve && (perf_mispreds_q != '1)) perf_mispreds_q <= perf_mispreds_q + 1'b1;
      if ((alloc_req != '0) && (free_count_q == '0) && (perf_full_stalls_q != '1)) begin
        perf_full_stalls_q <= perf_full_stalls_q + 1'b1;
      end
    end
  end

  assign perf_allocs      = perf_allocs_q;
  assign perf_mispreds    = perf_mispreds_q;
  assign perf_full_stalls = perf_full_stalls_q;
`endif

`ifndef SYNTHESIS
  illegal_resolve_a: assert property (@(posedge clock) disable iff (!reset_n)
    resolve_valid |-> legal_resolve)
    else $warning("branch_tag_allocator: resolve of non-live or non-one-hot tag ignored");
`endif

endmodule
